video_wr_packer: RTL and testbench

Pixel packer that sits directly upstream of the DDR3 write address/command stage in the DMA_APP write path. It accepts a frame-synchronised pixel stream (vsync, data-enable, one pixel per clock), packs pixels LSB-first into 256-bit words and drives `Pre_wren`/`Pre_wdata`. It also enforces exact frame length, so the downstream burst counter and frame-address wrap stay aligned.

---
 rtl/video_wr_packer_if.sv | 24 ++
 rtl/video_wr_packer.sv | 172 +++++++++++++++++
 tb/tb_video_wr_packer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/video_wr_packer_if.sv
// Pixel-in / packed-word-out bundle for video_wr_packer.
// slave = packer side, master = pixel source and write-stage side.
interface video_wr_packer_if #(
    parameter int Pixel_wd = 2
);
    logic                    I_vs;
    logic                    I_de;
    logic [8*Pixel_wd-1:0]   I_pixel;
    logic                    Pre_wren;
    logic [255:0]            Pre_wdata;
    logic                    O_frame_done;
    logic                    O_err_short;
    logic                    O_err_long;

    modport slave (
        input  I_vs, I_de, I_pixel,
        output Pre_wren, Pre_wdata, O_frame_done, O_err_short, O_err_long
    );

    modport master (
        output I_vs, I_de, I_pixel,
        input  Pre_wren, Pre_wdata, O_frame_done, O_err_short, O_err_long
    );
endinterface

// File: rtl/video_wr_packer.sv
// Packs a vsync/de pixel stream LSB-first into 256-bit words and enforces frame length.
// Define VIDEO_WR_PACKER_PAD_EN to zero-pad short frames up to FRAME_WORDS.
module video_wr_packer #(
    parameter int IW       = 1024,
    parameter int IH       = 768,
    parameter int Pixel_wd = 2
) (
    input  logic             I_clk,
    input  logic             I_Rst,
    video_wr_packer_if.slave bus
);

    localparam int PIX_BITS    = 8 * Pixel_wd;
    localparam int PPW         = 32 / Pixel_wd;
    localparam int FRAME_WORDS = IW * IH * Pixel_wd / 32;
    localparam int PCW         = $clog2(PPW);
    localparam int WCW         = $clog2(FRAME_WORDS + 1);

    localparam logic [PCW-1:0] PIX_LAST  = PCW'(PPW - 1);
    localparam logic [WCW-1:0] WORD_FULL = WCW'(FRAME_WORDS);

    localparam logic [1:0] ST_WAIT_VS = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
`ifdef VIDEO_WR_PACKER_PAD_EN
    localparam logic [1:0] ST_PAD     = 2'd2;
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);
`endif

    logic [1:0]          state_q, state_d;
    logic                vs_d_q, vs_d_d;
    logic [PCW-1:0]      pix_cnt_q, pix_cnt_d;
    logic [WCW-1:0]      word_cnt_q, word_cnt_d;
    logic [255:0]        shift_q, shift_d;
    logic                long_seen_q, long_seen_d;
    logic                wren_q, wren_d;
    logic [255:0]        wdata_q, wdata_d;
    logic                frame_done_q, frame_done_d;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;

    logic                vs_rise;
    logic                take_px;
    logic [PIX_BITS-1:0] pixel;

    assign pixel   = bus.I_pixel;
    assign vs_rise = bus.I_vs & ~vs_d_q;

    // The vs edge is resolved first; take_px then decides whether this cycle's
    // pixel lands in the (possibly freshly cleared) frame.
    always_comb begin
        state_d      = state_q;
        vs_d_d       = bus.I_vs;
        pix_cnt_d    = pix_cnt_q;
        word_cnt_d   = word_cnt_q;
        shift_d      = shift_q;
        long_seen_d  = long_seen_q;
        wren_d       = 1'b0;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;
        take_px      = 1'b0;

        case (state_q)
            ST_WAIT_VS: begin
                if (vs_rise) begin
                    state_d     = ST_ACTIVE;
                    pix_cnt_d   = '0;
                    word_cnt_d  = '0;
                    shift_d     = '0;
                    long_seen_d = 1'b0;
                    take_px     = bus.I_de;
                end
            end
            ST_ACTIVE: begin
                if (vs_rise && !(word_cnt_q == WORD_FULL && pix_cnt_q == '0)) begin
                    err_short_d = 1'b1;
`ifdef VIDEO_WR_PACKER_PAD_EN
                    state_d = ST_PAD;
`else
                    pix_cnt_d   = '0;
                    word_cnt_d  = '0;
                    shift_d     = '0;
                    long_seen_d = 1'b0;
                    take_px     = bus.I_de;
`endif
                end else begin
                    if (vs_rise) begin
                        pix_cnt_d   = '0;
                        word_cnt_d  = '0;
                        shift_d     = '0;
                        long_seen_d = 1'b0;
                    end
                    take_px = bus.I_de;
                end
            end
`ifdef VIDEO_WR_PACKER_PAD_EN
            ST_PAD: begin
                // shift_q holds the zero-filled partial word only on the first pad cycle
                wren_d     = 1'b1;
                wdata_d    = shift_q;
                shift_d    = '0;
                pix_cnt_d  = '0;
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_q == WORD_LAST) begin
                    frame_done_d = 1'b1;
                    word_cnt_d   = '0;
                    long_seen_d  = 1'b0;
                    state_d      = ST_ACTIVE;
                end
            end
`endif
            default: state_d = ST_WAIT_VS;
        endcase

        if (take_px) begin
            if (word_cnt_d == WORD_FULL) begin
                if (!long_seen_d) begin
                    err_long_d  = 1'b1;
                    long_seen_d = 1'b1;
                end
            end else begin
                shift_d[pix_cnt_d*PIX_BITS +: PIX_BITS] = pixel;
                if (pix_cnt_d == PIX_LAST) begin
                    wren_d       = 1'b1;
                    wdata_d      = shift_d;
                    shift_d      = '0;
                    pix_cnt_d    = '0;
                    word_cnt_d   = word_cnt_d + 1'b1;
                    frame_done_d = (word_cnt_d == WORD_FULL);
                end else begin
                    pix_cnt_d = pix_cnt_d + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_Rst) begin
            state_q      <= ST_WAIT_VS;
            vs_d_q       <= 1'b1;
            pix_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            long_seen_q  <= 1'b0;
            wren_q       <= 1'b0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_d_q       <= vs_d_d;
            pix_cnt_q    <= pix_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shift_q      <= shift_d;
            long_seen_q  <= long_seen_d;
            wren_q       <= wren_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
        end
    end

    assign bus.Pre_wren     = wren_q;
    assign bus.Pre_wdata    = wdata_q;
    assign bus.O_frame_done = frame_done_q;
    assign bus.O_err_short  = err_short_q;
    assign bus.O_err_long   = err_long_q;

endmodule

// File: tb/tb_video_wr_packer.sv
// Bench for video_wr_packer at IW=16, IH=2, Pixel_wd=2: directed frames then random ones,
// checked every cycle against a pixel-queue model of a frame.
module tb_video_wr_packer;

    localparam int IW       = 16;
    localparam int IH       = 2;
    localparam int PXW      = 2;
    localparam int PPW      = 32 / PXW;
    localparam int FULL_PX  = IW * IH;
`ifdef VIDEO_WR_PACKER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    video_wr_packer_if #(.Pixel_wd(PXW)) bus ();

    video_wr_packer #(.IW(IW), .IH(IH), .Pixel_wd(PXW)) dut (
        .I_clk (clk),
        .I_Rst (rst),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int n_strobe = 0;
    logic [255:0] last_wdata;

    // Model: the frame is the list of accepted pixels; padding appends zero pixels.
    int           mode;          // 0 waiting for vs, 1 active, 2 padding
    logic [15:0]  fpx[$];
    bit           m_vs_prev;
    bit           m_long;
    logic         e_wren, e_done, e_es, e_el;
    logic [255:0] e_wdata;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [255:0] pack_word(input int k);
        logic [255:0] w;
        w = '0;
        for (int i = 0; i < PPW; i++) w[i*16 +: 16] = fpx[k*PPW + i];
        return w;
    endfunction

    task automatic model_step(input logic r, input logic v, input logic d, input logic [15:0] p);
        bit rise;
        if (r) begin
            mode = 0; fpx.delete(); m_vs_prev = 1'b1; m_long = 1'b0;
            e_wren = 0; e_done = 0; e_es = 0; e_el = 0; e_wdata = '0;
            return;
        end
        e_wren = 0; e_done = 0; e_es = 0; e_el = 0;
        rise = v && !m_vs_prev;
        m_vs_prev = v;
        if (mode == 2) begin
            fpx.push_back(16'h0);
            while (fpx.size() % PPW != 0) fpx.push_back(16'h0);
            e_wren  = 1'b1;
            e_wdata = pack_word(fpx.size() / PPW - 1);
            if (fpx.size() == FULL_PX) begin
                e_done = 1'b1; fpx.delete(); m_long = 1'b0; mode = 1;
            end
            return;
        end
        if (rise) begin
            if (mode == 0) begin
                mode = 1; fpx.delete(); m_long = 1'b0;
            end else if (fpx.size() == FULL_PX) begin
                fpx.delete(); m_long = 1'b0;
            end else begin
                e_es = 1'b1;
                if (PAD) begin
                    mode = 2;
                    return;
                end
                fpx.delete(); m_long = 1'b0;
            end
        end
        if (mode == 1 && d) begin
            if (fpx.size() == FULL_PX) begin
                if (!m_long) begin e_el = 1'b1; m_long = 1'b1; end
            end else begin
                fpx.push_back(p);
                if (fpx.size() % PPW == 0) begin
                    e_wren  = 1'b1;
                    e_wdata = pack_word(fpx.size() / PPW - 1);
                    e_done  = (fpx.size() == FULL_PX);
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic d, input logic [15:0] p);
        rst = r; bus.I_vs = v; bus.I_de = d; bus.I_pixel = p;
        @(posedge clk);
        model_step(r, v, d, p);
        #1;
        check("wren",  {255'd0, bus.Pre_wren},     {255'd0, e_wren});
        check("wdata", bus.Pre_wdata,              e_wdata);
        check("done",  {255'd0, bus.O_frame_done}, {255'd0, e_done});
        check("short", {255'd0, bus.O_err_short},  {255'd0, e_es});
        check("long",  {255'd0, bus.O_err_long},   {255'd0, e_el});
        if (bus.Pre_wren) begin
            n_strobe++;
            last_wdata = bus.Pre_wdata;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic vs_pulse();
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic pixels(input int n, input int base);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 16'(base + i));
    endtask

    logic [255:0] word1_exp;
    int s0;

    initial begin
        rst = 1'b1; bus.I_vs = 1'b0; bus.I_de = 1'b0; bus.I_pixel = '0;
        last_wdata = '0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0);

        // de before the first vs edge is ignored
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 16'(i + 100));
        check("no_strobe_pre_vs", 256'(n_strobe), 256'd0);

        // clean frame 0..31
        s0 = n_strobe;
        vs_pulse();
        pixels(32, 0);
        idle(2);
        check("strobes_clean", 256'(n_strobe - s0), 256'd2);
        for (int i = 0; i < PPW; i++) word1_exp[i*16 +: 16] = 16'(16 + i);
        check("word1_clean", last_wdata, word1_exp);

        // clean frame plus 5 extra pixels
        s0 = n_strobe;
        vs_pulse();
        pixels(37, 200);
        idle(3);
        check("strobes_long", 256'(n_strobe - s0), 256'd2);

        // short frame of 20 pixels, then a full frame
        vs_pulse();
        pixels(20, 300);
        vs_pulse();
        idle(4);
        pixels(32, 400);
        idle(2);
        vs_pulse();
        idle(2);

        // reset mid-frame, then pixels without vs, then a real frame
        vs_pulse();
        pixels(10, 500);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        s0 = n_strobe;
        pixels(16, 600);
        check("no_strobe_after_rst", 256'(n_strobe - s0), 256'd0);
        vs_pulse();
        pixels(16, 700);
        idle(2);
        check("strobe_after_rst", 256'(n_strobe - s0), 256'd1);

        // random frames: lengths around FULL_PX, de gaps, vs/de coincidence, rare resets
        for (int f = 0; f < 150; f++) begin
            int npix, vs_len;
            npix = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : FULL_PX;
            vs_len = $urandom_range(1, 3);
            for (int i = 0; i < vs_len; i++)
                cyc(1'b0, 1'b1, (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom));
            for (int i = 0; i < npix; i++) begin
                while ($urandom_range(0, 4) == 0) cyc(1'b0, 1'b0, 1'b0, 16'($urandom));
                if ($urandom_range(0, 299) == 0) cyc(1'b1, 1'b0, 1'b0, 16'h0);
                else cyc(1'b0, 1'b0, 1'b1, 16'($urandom));
            end
            idle($urandom_range(3, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
